// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared encodings for the single-cycle processor controller:
//               instruction classes, data-proc commands, condition codes,
//               ALU operation codes and the run/halt state type.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Instruction class carried in the op field
    typedef enum logic [1:0] {
        OP_DP    = 2'b00,
        OP_MEM   = 2'b01,
        OP_BR    = 2'b10,
        OP_UNDEF = 2'b11
    } op_e;

    // Data-processing command field values (funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // Condition field values
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // ALU operation codes driven onto alu_control
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_ORR  = 4'b0011;
    localparam logic [3:0] ALU_EOR  = 4'b0100;
    localparam logic [3:0] ALU_MOVB = 4'b0101;

    // Controller run/halt state
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // True for the data-proc commands the datapath implements
    function automatic logic cmd_supported(input logic [3:0] cmd);
        logic ok;
        ok = 1'b0;
        case (cmd)
            CMD_AND, CMD_EOR, CMD_SUB, CMD_ADD,
            CMD_CMP, CMD_ORR, CMD_MOV: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ALU operation for a data-proc command; CMP is a subtract without writeback
    function automatic logic [3:0] alu_for_cmd(input logic [3:0] cmd);
        logic [3:0] code;
        code = ALU_ADD;
        case (cmd)
            CMD_AND: code = ALU_AND;
            CMD_EOR: code = ALU_EOR;
            CMD_SUB: code = ALU_SUB;
            CMD_ADD: code = ALU_ADD;
            CMD_CMP: code = ALU_SUB;
            CMD_ORR: code = ALU_ORR;
            CMD_MOV: code = ALU_MOVB;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
// Module      : cond_check
// Description : Combinational condition-code evaluator. Decides whether an
//               instruction executes given its cond field and the NZCV flags.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_check
    import ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,   // {N, Z, C, V}
    output logic       pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign {w_n, w_z, w_c, w_v} = flags;

    // Evaluate the condition; NV (1111) never executes
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = w_z;
            COND_NE: pass = ~w_z;
            COND_CS: pass = w_c;
            COND_CC: pass = ~w_c;
            COND_MI: pass = w_n;
            COND_PL: pass = ~w_n;
            COND_VS: pass = w_v;
            COND_VC: pass = ~w_v;
            COND_HI: pass = w_c & ~w_z;
            COND_LS: pass = ~w_c | w_z;
            COND_GE: pass = (w_n == w_v);
            COND_LT: pass = (w_n != w_v);
            COND_GT: pass = ~w_z & (w_n == w_v);
            COND_LE: pass = w_z | (w_n != w_v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Main controller of the single-cycle processor. Decodes the
//               instruction fields into datapath strobes, keeps the NZCV flag
//               register and halts the core on any unsupported encoding.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import ctrl_pkg::*;
#(
    parameter int ALU_W  = 4,
    parameter int FLAG_W = 5
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active low
    input  logic [3:0]        cond,
    input  logic [1:0]        op,
    input  logic [5:0]        funct,
    input  logic [3:0]        rd,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              pc_src,
    output logic              mem_to_reg,
    output logic              mem_write,
    output logic [ALU_W-1:0]  alu_control,
    output logic              alu_src,
    output logic              reg_write,
    output logic [1:0]        reg_src,
    output logic              pc_en,
    output logic              halted,
    output logic [3:0]        flags_q
);

    state_e     r_state;
    state_e     w_state_next;
    logic [3:0] r_flags;

    op_e        w_op;
    logic [3:0] w_cmd;
    logic       w_s;
    logic       w_pass;
    logic       w_illegal;
    logic       w_active;
    logic       w_flag_we;
    logic       w_arith;
    logic [3:0] w_alu;
    logic       w_unused_flag_hi;

    assign w_op    = op_e'(op);
    assign w_cmd   = funct[4:1];
    assign w_s     = funct[0];

    // Only NZCV is architectural; the upper flag bits are don't-care
    assign w_unused_flag_hi = ^alu_flags[FLAG_W-1:4];

    cond_check u_cond_check (
        .cond  (cond),
        .flags (r_flags),
        .pass  (w_pass)
    );

    // Unsupported encodings: undefined class, unknown data-proc command,
    // or a branch with the link bit set
    assign w_illegal = (w_op == OP_UNDEF)
                     | ((w_op == OP_DP) & ~cmd_supported(w_cmd))
                     | ((w_op == OP_BR) & funct[4]);

    // The offending instruction is already suppressed in its own cycle
    assign w_active  = (r_state == ST_RUN) & ~w_illegal;

    // C and V are only meaningful for the arithmetic commands
    assign w_arith   = (w_cmd == CMD_ADD) | (w_cmd == CMD_SUB) | (w_cmd == CMD_CMP);

    assign w_flag_we = w_active & w_pass & (w_op == OP_DP) & (w_s | (w_cmd == CMD_CMP));

    // State register: asynchronous reset back to RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: any illegal instruction in RUN parks the core in HALT for good
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:  if (w_illegal) w_state_next = ST_HALT;
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_HALT;
        endcase
    end

    // Flag register: N/Z always load on update, C/V hold for logical ops and MOV
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags <= 4'b0000;
        end else if (w_flag_we) begin
            r_flags[3] <= alu_flags[3];
            r_flags[2] <= alu_flags[2];
            if (w_arith) begin
                r_flags[1] <= alu_flags[1];
                r_flags[0] <= alu_flags[0];
            end
        end
    end

    // Strobe decode; everything defaults to zero so HALT/illegal need no branch
    always_comb begin
        pc_src     = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        w_alu      = ALU_ADD;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        reg_src    = 2'b00;
        pc_en      = 1'b0;
        if (w_active) begin
            pc_en = 1'b1;
            case (w_op)
                OP_DP: begin
                    alu_src   = funct[5];
                    w_alu     = alu_for_cmd(w_cmd);
                    reg_write = w_pass & (w_cmd != CMD_CMP);
                    pc_src    = w_pass & (w_cmd != CMD_CMP) & (rd == 4'd15);
                end
                OP_MEM: begin
                    alu_src = 1'b1;
                    w_alu   = funct[3] ? ALU_ADD : ALU_SUB;
                    if (funct[0]) begin
                        reg_write  = w_pass;
                        mem_to_reg = 1'b1;
                        pc_src     = w_pass & (rd == 4'd15);
                    end else begin
                        mem_write = w_pass;
                        reg_src   = 2'b01;
                    end
                end
                OP_BR: begin
                    reg_src = 2'b10;
                    alu_src = 1'b1;
                    w_alu   = ALU_ADD;
                    pc_src  = w_pass;
                end
                default: begin
                    pc_en = 1'b0;
                end
            endcase
        end
        // Reset low blocks every state-changing strobe immediately
        if (!rst) begin
            reg_write = 1'b0;
            mem_write = 1'b0;
            pc_src    = 1'b0;
            pc_en     = 1'b0;
        end
    end

    assign alu_control = ALU_W'(w_alu);
    assign halted      = (r_state == ST_HALT);
    assign flags_q     = r_flags;

endmodule
`default_nettype wire

// File: doc/control_unit.md
Name: control_unit

Overview:
Main controller of the single-cycle processor. It sits directly upstream of the datapath.
- Inputs: the decoded instruction fields (cond, op, funct, rd) and the ALU flags, all returned by the datapath.
- Outputs: the datapath control strobes.
- State held: the architectural NZCV flag register and a run/halt state machine.
- Halt condition: any unsupported encoding halts the core until reset.

Parameters:
ALU_W, 4, width of alu_control
FLAG_W, 5, width of alu_flags input; bits [3:0] = N,Z,C,V; bit 4 is ignored

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
cond  in  4  instruction condition field
op  in  2  instruction class: 00 data-proc, 01 memory, 10 branch, 11 undefined
funct  in  6  [5]=I, [4:1]=cmd, [0]=S (data-proc); [3]=U, [0]=L (memory); [4]=link (branch)
rd  in  4  destination register
alu_flags  in  5  live ALU flags {x,N,Z,C,V}
pc_src  out  1  1 = PC loads datapath result
mem_to_reg  out  1  1 = result taken from data memory
mem_write  out  1  data memory write strobe
alu_control  out  4  ALU operation code
alu_src  out  1  1 = ALU B operand is the immediate
reg_write  out  1  register file write strobe
reg_src  out  2  [1]=1 selects R15 for port A; [0]=1 selects Rd for port B
pc_en  out  1  PC update enable; 0 freezes the PC
halted  out  1  core is in HALT
flags_q  out  4  registered NZCV, for debug

Behaviour:
- All strobe outputs are combinational from the current fields, flags_q and state. Zero latency; same cycle as the instruction.
- State machine, two states:
  - RUN → HALT when op=11, or a data-proc cmd is outside {AND 0000, EOR 0001, SUB 0010, ADD 0100, CMP 1010, ORR 1100, MOV 1101}, or a branch has funct[4]=1.
  - HALT is sticky; only rst exits it.
- The transition is evaluated at the posedge. The offending instruction itself is already suppressed in its own cycle.
- In HALT, or on an illegal instruction:
  - reg_write=mem_write=pc_src=pc_en=0.
  - Remaining outputs are 0.
  - halted=1 only once the state is HALT.
- Condition pass, from flags_q:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z.
  - GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 never passes (no halt).
- Condition fail: reg_write=mem_write=pc_src=0, no flag update, pc_en=1 (instruction acts as a NOP).
- Data-proc decode:
  - alu_src=funct[5]; reg_src=00; mem_to_reg=0.
  - alu_control from the package table.
  - reg_write=pass, except CMP (0).
  - pc_src=pass & reg_write & (rd==15).
- Memory decode:
  - alu_src=1; alu_control=ADD if U=1, else SUB.
  - LDR (L=1): reg_write=pass, mem_to_reg=1, reg_src=00, pc_src=pass & (rd==15).
  - STR (L=0): mem_write=pass, reg_src=01.
- Branch decode: reg_src=10; alu_src=1; alu_control=ADD; pc_src=pass; no writes.
- Flag register update (at posedge, when RUN & pass & data-proc & (S=1 or CMP)):
  - N, Z always load from alu_flags.
  - C, V load only for ADD/SUB/CMP; they hold for logical ops and MOV.
- S bit on memory or branch instructions is ignored.
- Reset: flags_q=0000, state=RUN, halted=0.
- Mid-cycle rst assertion forces reg_write=mem_write=pc_src=pc_en=0 while low.
- pc_en=1 in RUN whenever rst is high.

Decomposition:
- ctrl_pkg holds:
  - op enum;
  - cmd constants;
  - cond code constants;
  - ALU codes: ALU_ADD 0000, ALU_SUB 0001, ALU_AND 0010, ALU_ORR 0011, ALU_EOR 0100, ALU_MOVB 0101;
  - state enum {RUN, HALT}.
- One sub-module, cond_check: combinational; inputs cond and flags; output pass.

Test Plan:
- Reset then ADD AL S=1 with alu_flags=0_0110 → reg_write=1, alu_control=0000; next cycle flags_q=0110.
- flags_q Z=1, then SUB NE, rd=3 → reg_write=0, pc_en=1; flags_q unchanged.
- ORR S=1 with C=1 held, alu_flags C=0, N=1 → flags_q N=1, C still 1.
- STR AL U=0 → mem_write=1, reg_src=01, alu_src=1, alu_control=0001; LDR rd=15 → pc_src=1, mem_to_reg=1.
- Branch GT with flags N=V=1, Z=0 → pc_src=1, reg_src=10; same with Z=1 → pc_src=0.
- op=11 → writes 0 that cycle, halted=1 next cycle, ADD AL stays suppressed; rst low→high → halted=0, flags_q=0000.
